// File: rtl/dac_stream_arbiter_if.sv
// Stream bundle around the arbiter: N_REQ channel-side AXI4-Stream inputs
// packed side by side, plus the single DAC-side AXI4-Stream output.
// Handshake: a beat transfers on a rising clock edge where tvalid and tready
// are both high; a source holds tdata/tlast stable while tvalid is high and
// tready is low, and tvalid never waits on tready.
interface dac_stream_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 32
);
    logic [N_REQ*DATA_W-1:0] s_axis_tdata;
    logic [N_REQ-1:0]        s_axis_tvalid;
    logic [N_REQ-1:0]        s_axis_tlast;
    logic [N_REQ-1:0]        s_axis_tready;
    logic [DATA_W-1:0]       m_axis_tdata;
    logic                    m_axis_tvalid;
    logic                    m_axis_tlast;
    logic                    m_axis_tready;

    // Arbiter side: consumes channel streams, produces the DAC stream
    modport master (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
    );

    // Environment side: pulse engines and DAC skid buffer
    modport slave (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
    );
endinterface

// File: rtl/dac_stream_arbiter.sv
// Packet-level round-robin arbiter sharing one DAC stream between N_REQ
// pulse-engine channels. A grant lasts until the TLAST handshake; a beat
// counter forces TLAST after MAX_BEATS beats so no channel can hog the DAC.
module dac_stream_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 32,
    parameter int MAX_BEATS = 1024,
    localparam int GW       = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int CW       = $clog2(MAX_BEATS + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    dac_stream_arbiter_if.master  bus,
    output logic                  grant_valid,
    output logic [GW-1:0]         grant_id,
    output logic                  overlong_err,
    output logic [0:0]            o_dbg_state
);
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]    r_state;
    logic [GW-1:0] r_grant_id;
    logic [GW-1:0] r_last_grant;
    logic [CW-1:0] r_beat_cnt;
    logic          r_overlong_err;

    logic          w_locked;
    logic          w_found;
    logic [GW-1:0] w_pick;
    logic          w_force_last;
    logic          w_ch_last;
    logic          w_beat;
    int            w_idx;

    assign w_locked = (r_state == ST_LOCKED);

    // Round-robin pick: scan from the far end so the nearest valid channel
    // after last_grant overwrites earlier candidates and wins.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_last_grant;
        w_idx   = 0;
        for (int k = N_REQ; k >= 1; k--) begin
            w_idx = (int'(r_last_grant) + k) % N_REQ;
            if (bus.s_axis_tvalid[w_idx]) begin
                w_found = 1'b1;
                w_pick  = GW'(w_idx);
            end
        end
    end

    assign w_force_last = (r_beat_cnt == CW'(MAX_BEATS - 1));
    assign w_ch_last    = bus.s_axis_tlast[r_grant_id];

    // Combinational pass-through of the granted channel; nothing is stored,
    // so the only path from m_axis_tready is into s_axis_tready.
    always_comb begin
        bus.m_axis_tdata  = bus.s_axis_tdata[r_grant_id*DATA_W +: DATA_W];
        bus.m_axis_tvalid = w_locked & bus.s_axis_tvalid[r_grant_id];
        bus.m_axis_tlast  = w_locked & (w_ch_last | w_force_last);
        bus.s_axis_tready = '0;
        if (w_locked) begin
            bus.s_axis_tready[r_grant_id] = bus.m_axis_tready;
        end
    end

    assign w_beat = bus.m_axis_tvalid & bus.m_axis_tready;

    // Grant FSM: IDLE picks a winner (one bubble cycle), LOCKED holds it
    // until the TLAST beat, whether the TLAST came from the channel or was forced.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_grant_id     <= '0;
            r_last_grant   <= GW'(N_REQ - 1);
            r_beat_cnt     <= '0;
            r_overlong_err <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (enable && w_found) begin
                        r_grant_id <= w_pick;
                        r_beat_cnt <= '0;
                        r_state    <= ST_LOCKED;
                    end
                end
                default: begin
                    if (w_beat) begin
                        if (bus.m_axis_tlast) begin
                            r_state      <= ST_IDLE;
                            r_last_grant <= r_grant_id;
                            if (w_force_last && !w_ch_last) begin
                                r_overlong_err <= 1'b1;
                            end
                        end else begin
                            r_beat_cnt <= r_beat_cnt + CW'(1);
                        end
                    end
                end
            endcase
        end
    end

    assign grant_valid  = w_locked;
    assign grant_id     = r_grant_id;
    assign overlong_err = r_overlong_err;
    assign o_dbg_state  = r_state;
endmodule

// File: tb/tb_dac_stream_arbiter.sv
// Directed bench for dac_stream_arbiter (N_REQ=4, DATA_W=32, MAX_BEATS=4).
module tb_dac_stream_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       grant_valid;
    logic [1:0] grant_id;
    logic       overlong_err;
    logic [0:0] dbg_state;

    logic [DW-1:0] ch_dat [N];
    logic [DW-1:0] exp_q [$];

    int n_checks = 0;
    int n_errors = 0;

    dac_stream_arbiter_if #(.N_REQ(N), .DATA_W(DW)) bus ();

    dac_stream_arbiter #(.N_REQ(N), .DATA_W(DW), .MAX_BEATS(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .bus          (bus),
        .grant_valid  (grant_valid),
        .grant_id     (grant_id),
        .overlong_err (overlong_err),
        .o_dbg_state  (dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [3:0]  vld;
        logic [3:0]  lst;
        logic        rdy;
        logic [31:0] dat;
        logic        e_mv;
        logic        e_ml;
        logic [31:0] e_md;
        logic [3:0]  e_sr;
        logic        e_gv;
        logic [1:0]  e_gid;
    } vec_t;

    vec_t tbl [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic en, input logic [3:0] vld, input logic [3:0] lst,
                         input logic rdy);
        enable               = en;
        bus.s_axis_tvalid    = vld;
        bus.s_axis_tlast     = lst;
        bus.m_axis_tready    = rdy;
        bus.s_axis_tdata     = {ch_dat[3], ch_dat[2], ch_dat[1], ch_dat[0]};
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) ch_dat[i] = '0;
        drive(1'b0, 4'h0, 4'h0, 1'b0);
        @(negedge clk);
        chk("rst_gv", grant_valid, 0);
        chk("rst_mv", bus.m_axis_tvalid, 0);
        chk("rst_ml", bus.m_axis_tlast, 0);
        chk("rst_sr", bus.s_axis_tready, 0);
        chk("rst_gid", grant_id, 0);
        chk("rst_err", overlong_err, 0);
        chk("rst_state", dbg_state, 0);
        rst_n = 1'b1;
    endtask

    function automatic vec_t mk(logic en, logic [3:0] vld, logic [3:0] lst, logic rdy,
                                logic [31:0] dat, logic e_mv, logic e_ml, logic [31:0] e_md,
                                logic [3:0] e_sr, logic e_gv, logic [1:0] e_gid);
        vec_t v;
        v.en = en; v.vld = vld; v.lst = lst; v.rdy = rdy; v.dat = dat;
        v.e_mv = e_mv; v.e_ml = e_ml; v.e_md = e_md; v.e_sr = e_sr;
        v.e_gv = e_gv; v.e_gid = e_gid;
        return v;
    endfunction

    // Channel i presents dat | (i << 8); data is only compared when valid is expected.
    task automatic run_table();
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            for (int c = 0; c < N; c++) ch_dat[c] = tbl[i].dat | (32'(c) << 8);
            drive(tbl[i].en, tbl[i].vld, tbl[i].lst, tbl[i].rdy);
            #1;
            chk($sformatf("tbl%0d_mv", i), bus.m_axis_tvalid, tbl[i].e_mv);
            chk($sformatf("tbl%0d_ml", i), bus.m_axis_tlast, tbl[i].e_ml);
            chk($sformatf("tbl%0d_sr", i), bus.s_axis_tready, tbl[i].e_sr);
            chk($sformatf("tbl%0d_gv", i), grant_valid, tbl[i].e_gv);
            chk($sformatf("tbl%0d_gid", i), grant_id, tbl[i].e_gid);
            if (tbl[i].e_mv) chk($sformatf("tbl%0d_md", i), bus.m_axis_tdata, tbl[i].e_md);
        end
        tbl.delete();
    endtask

    initial begin
        int b;
        bit done;
        logic [3:0] pat;
        logic [31:0] got;

        do_reset();

        // Single channel: ch1 3-beat packet, one bubble cycle, then 3 beats
        tbl.push_back(mk(1, 4'b0010, 4'b0000, 1, 32'hA1, 0, 0, 32'h0,   4'b0000, 0, 0));
        tbl.push_back(mk(1, 4'b0010, 4'b0000, 1, 32'hA1, 1, 0, 32'h1A1, 4'b0010, 1, 1));
        tbl.push_back(mk(1, 4'b0010, 4'b0000, 1, 32'hA2, 1, 0, 32'h1A2, 4'b0010, 1, 1));
        tbl.push_back(mk(1, 4'b0010, 4'b0010, 1, 32'hA3, 1, 1, 32'h1A3, 4'b0010, 1, 1));
        tbl.push_back(mk(1, 4'b0000, 4'b0000, 1, 32'h00, 0, 0, 32'h0,   4'b0000, 0, 1));
        run_table();

        // Round-robin: all channels valid, 2-beat packets, order 0,1,2,3,0
        do_reset();
        for (int p = 0; p < 5; p++) begin
            int g;
            int pg;
            g  = p % 4;
            pg = (p == 0) ? 0 : (p - 1) % 4;
            tbl.push_back(mk(1, 4'hF, 4'h0, 1, 32'h0, 0, 0, 32'h0, 4'h0, 0, 2'(pg)));
            tbl.push_back(mk(1, 4'hF, 4'h0, 1, 32'h10 + 32'(p), 1, 0,
                             (32'h10 + 32'(p)) | (32'(g) << 8), 4'(1 << g), 1, 2'(g)));
            tbl.push_back(mk(1, 4'hF, 4'hF, 1, 32'h20 + 32'(p), 1, 1,
                             (32'h20 + 32'(p)) | (32'(g) << 8), 4'(1 << g), 1, 2'(g)));
        end
        run_table();

        // Backpressure: ch0 4-beat packet, ready pattern 1,0,0,1 repeating
        do_reset();
        exp_q = {32'hB0, 32'hB1, 32'hB2, 32'hB3};
        pat = 4'b1001;
        b = 0;
        done = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            logic rdy;
            @(negedge clk);
            rdy = pat[c % 4];
            ch_dat[0] = 32'hB0 + 32'(b);
            drive(1, 4'b0001, (b == 3) ? 4'b0001 : 4'b0000, rdy);
            #1;
            if (grant_valid) begin
                chk("bp_mv", bus.m_axis_tvalid, 1);
                chk("bp_md", bus.m_axis_tdata, 32'hB0 + 32'(b));
                chk("bp_sr", bus.s_axis_tready, {3'b000, rdy});
                if (rdy) begin
                    got = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD;
                    chk("bp_beat", bus.m_axis_tdata, got);
                    chk("bp_ml", bus.m_axis_tlast, (b == 3) ? 1 : 0);
                    if (b == 3) done = 1;
                    b++;
                end
            end
        end
        chk("bp_done", done, 1);
        chk("bp_q_empty", exp_q.size(), 0);
        @(negedge clk);
        drive(1, 4'b0000, 4'b0000, 1);
        #1;
        chk("bp_idle", grant_valid, 0);

        // Enable: drop enable mid-packet, packet completes, no new grant until re-enabled
        do_reset();
        ch_dat[0] = 32'hE0; ch_dat[1] = 32'hE1;
        @(negedge clk); drive(1, 4'b0001, 4'b0000, 1); #1;
        chk("en_idle", grant_valid, 0);
        @(negedge clk); drive(0, 4'b0001, 4'b0000, 1); #1;
        chk("en_gv1", grant_valid, 1);
        chk("en_md1", bus.m_axis_tdata, 32'hE0);
        @(negedge clk); drive(0, 4'b0001, 4'b0001, 1); #1;
        chk("en_gv2", grant_valid, 1);
        chk("en_ml2", bus.m_axis_tlast, 1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); drive(0, 4'b0011, 4'b0000, 1); #1;
            chk("en_blocked_gv", grant_valid, 0);
            chk("en_blocked_sr", bus.s_axis_tready, 0);
            chk("en_blocked_mv", bus.m_axis_tvalid, 0);
        end
        @(negedge clk); drive(1, 4'b0011, 4'b0000, 1); #1;
        chk("en_reidle", grant_valid, 0);
        @(negedge clk); drive(1, 4'b0011, 4'b0000, 1); #1;
        chk("en_regrant_gv", grant_valid, 1);
        chk("en_regrant_gid", grant_id, 1);
        chk("en_regrant_sr", bus.s_axis_tready, 4'b0010);

        // Overlong: ch2 6 beats with last on 6th; MAX_BEATS=4 forces last on 4th
        do_reset();
        ch_dat[3] = 32'hD0;
        @(negedge clk); drive(1, 4'b1100, 4'b1000, 1); #1;
        chk("ol_idle", grant_valid, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            ch_dat[2] = 32'hC0 + 32'(k);
            drive(1, 4'b1100, 4'b1000, 1); #1;
            chk("ol_gid", grant_id, 2);
            chk("ol_md", bus.m_axis_tdata, 32'hC0 + 32'(k));
            chk("ol_ml", bus.m_axis_tlast, (k == 3) ? 1 : 0);
            chk("ol_err_before", overlong_err, 0);
        end
        @(negedge clk); drive(1, 4'b1100, 4'b1000, 1); #1;
        chk("ol_err_set", overlong_err, 1);
        chk("ol_idle2", grant_valid, 0);
        @(negedge clk); drive(1, 4'b1100, 4'b1000, 1); #1;
        chk("ol_ch3_gid", grant_id, 3);
        chk("ol_ch3_md", bus.m_axis_tdata, 32'hD0);
        chk("ol_ch3_ml", bus.m_axis_tlast, 1);
        chk("ol_ch3_sr", bus.s_axis_tready, 4'b1000);
        @(negedge clk); drive(1, 4'b0100, 4'b0000, 1); #1;
        chk("ol_idle3", grant_valid, 0);
        for (int k = 4; k < 6; k++) begin
            @(negedge clk);
            ch_dat[2] = 32'hC0 + 32'(k);
            drive(1, 4'b0100, (k == 5) ? 4'b0100 : 4'b0000, 1); #1;
            chk("ol_tail_gid", grant_id, 2);
            chk("ol_tail_md", bus.m_axis_tdata, 32'hC0 + 32'(k));
            chk("ol_tail_ml", bus.m_axis_tlast, (k == 5) ? 1 : 0);
        end
        @(negedge clk); drive(1, 4'b0000, 4'b0000, 1); #1;
        chk("ol_err_sticky", overlong_err, 1);
        chk("ol_idle4", grant_valid, 0);

        // Reset mid-packet: async clear during beat 2, then channel 0 wins first
        ch_dat[0] = 32'h50;
        @(negedge clk); drive(1, 4'b0001, 4'b0000, 1);
        @(negedge clk); drive(1, 4'b0001, 4'b0000, 1); #1;
        chk("rm_beat1_gv", grant_valid, 1);
        @(negedge clk); drive(1, 4'b0001, 4'b0000, 1); #1;
        chk("rm_beat2_gv", grant_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("rm_async_gv", grant_valid, 0);
        chk("rm_async_mv", bus.m_axis_tvalid, 0);
        chk("rm_async_sr", bus.s_axis_tready, 0);
        chk("rm_async_err", overlong_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 4'b0011, 4'b0000, 1); #1;
        chk("rm_idle", grant_valid, 0);
        @(negedge clk); drive(1, 4'b0011, 4'b0000, 1); #1;
        chk("rm_first_gv", grant_valid, 1);
        chk("rm_first_gid", grant_id, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/dac_stream_arbiter.md
Name: dac_stream_arbiter

Overview:
Packet-level round-robin arbiter that shares one DAC AXI4-Stream between N pulse_engine channels. It sits between the per-channel pulse engines and the DAC-side skid buffer. A grant is held for a whole packet, until the TLAST handshake. An overlong-packet guard forces TLAST after MAX_BEATS beats, so one channel cannot starve the others.

Parameters:
N_REQ, 4, number of requesting channels (>=2)
DATA_W, 32, I/Q sample width
MAX_BEATS, 1024, max beats per grant before TLAST is forced (>=1)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
enable  input  1  arbitration enable; low blocks new grants, current packet finishes
s_axis_tdata  input  N_REQ*DATA_W  channel i data at bits [i*DATA_W +: DATA_W]
s_axis_tvalid  input  N_REQ  per-channel valid
s_axis_tlast  input  N_REQ  per-channel end-of-packet
s_axis_tready  output  N_REQ  per-channel ready
m_axis_tdata  output  DATA_W  downstream data
m_axis_tvalid  output  1  downstream valid
m_axis_tlast  output  1  downstream last (channel tlast OR forced)
m_axis_tready  input  1  downstream ready
grant_valid  output  1  high while LOCKED
grant_id  output  max(1,$clog2(N_REQ))  currently/last granted channel
overlong_err  output  1  sticky; set when TLAST is forced; cleared only by reset

Behaviour:
- Reset (async, rst_n low): state=IDLE, grant_id=0, last_grant=N_REQ-1 (channel 0 wins first), beat_cnt=0, overlong_err=0. All outputs that follow from this state are low: m_axis_tvalid, m_axis_tlast, s_axis_tready, grant_valid.
- States: IDLE, LOCKED.
- IDLE:
  - All s_axis_tready=0, m_axis_tvalid=0.
  - If enable && |s_axis_tvalid: pick the first valid channel scanning last_grant+1, last_grant+2, … modulo N_REQ. Register grant_id, set beat_cnt=0, go LOCKED.
  - This gives one bubble cycle per grant.
- LOCKED (granted channel g):
  - Pure combinational pass-through, no storage:
    - m_axis_tdata = s_axis_tdata[g]
    - m_axis_tvalid = s_axis_tvalid[g]
    - s_axis_tready[g] = m_axis_tready; all other readies = 0
  - force_last = (beat_cnt == MAX_BEATS-1).
  - m_axis_tlast = s_axis_tlast[g] | force_last. It is qualified only by being in LOCKED, not by valid.
  - beat = m_axis_tvalid && m_axis_tready. On each beat without end, beat_cnt increments.
  - On a beat with m_axis_tlast:
    - go IDLE and set last_grant=g.
    - If force_last && !s_axis_tlast[g], set overlong_err=1.
  - After a forced TLAST, the channel's remaining beats are a new packet and need re-arbitration.
- enable is sampled only in IDLE. Deassertion in LOCKED does not truncate the packet.
- grant_id holds its value in IDLE (last winner). grant_valid = (state==LOCKED).
- Channel valid dropping mid-packet: the arbiter stays LOCKED with m_axis_tvalid=0 and waits indefinitely. It never pre-empts.
- Simultaneous requests: round-robin only. Fairness guarantee: each persistently-requesting channel is granted within N_REQ grants.
- MAX_BEATS=1: every beat is forced last unless the channel asserts tlast on it.
- beat_cnt width is $clog2(MAX_BEATS+1) and never wraps; the count resets on grant.
- AXI rules:
  - Outputs depend combinationally on m_axis_tready only via s_axis_tready.
  - m_axis_tvalid never depends on m_axis_tready.

Test Plan:
- Single channel: ch1 sends 3-beat packet (0xA1,0xA2,0xA3 with last), m_axis_tready=1 -> one idle cycle, then 3 consecutive output beats with tlast on 0xA3; grant_id=1; returns IDLE.
- Round-robin: all 4 channels continuously valid with 2-beat packets -> grant order 0,1,2,3,0; s_axis_tready never high for a non-granted channel.
- Backpressure: ch0 packet 4 beats, m_axis_tready toggles 1,0,0,1,… -> data stable and tvalid held while tready=0; no beat lost or duplicated; s_axis_tready[0] mirrors m_axis_tready.
- Overlong: MAX_BEATS=4, ch2 sends 6 beats, last only on 6th -> m_axis_tlast on 4th beat; overlong_err=1 thereafter; ch3 (if valid) granted next; ch2's remaining 2 beats form a later packet ending in last.
- Enable: deassert enable during ch0 packet -> packet completes normally, then no grant while enable=0 despite valid; re-assert -> grant resumes with next round-robin channel.
- Reset mid-packet: assert rst_n low during LOCKED beat 2 -> all readies, m_axis_tvalid and grant_valid low immediately (async); overlong_err=0; after release, channel 0 wins first.
